// File: rtl/mux_5_to_1_if.sv
// Data/select bundle for mux_5_to_1: five data inputs, a 3-bit select,
// and the registered result plus the out-of-range select flag.
interface mux_5_to_1_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] ind;
  logic [WIDTH-1:0] ine;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out;
  logic             sel_err;

  modport master (
    output ina, inb, inc, ind, ine, sel,
    input  out, sel_err
  );

  modport slave (
    input  ina, inb, inc, ind, ine, sel,
    output out, sel_err
  );
endinterface

// File: rtl/mux_5_to_1.sv
// Registered 5:1 multiplexer. A select of 5..7 loads zeros and raises
// sel_err for that cycle. Reset is synchronous and active-high.
module mux_5_to_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  mux_5_to_1_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4
  } sel_e;

  logic [WIDTH-1:0] out_q;
  logic             sel_err_q;

  // Only the selected input reaches the register, so X/Z on any other input stays out.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      case (sel_e'(bus.sel))
        SEL_A:   out_q <= bus.ina;
        SEL_B:   out_q <= bus.inb;
        SEL_C:   out_q <= bus.inc;
        SEL_D:   out_q <= bus.ind;
        SEL_E:   out_q <= bus.ine;
        default: begin
          out_q     <= '0;
          sel_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out     = out_q;
  assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_5_to_1.sv
// Directed bench for mux_5_to_1: a 1-bit and an 8-bit instance share
// the clock and reset, and are checked against hand-computed values.
module tb_mux_5_to_1;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mux_5_to_1_if #(.WIDTH(1)) b1 ();
  mux_5_to_1_if #(.WIDTH(8)) b8 ();

  mux_5_to_1 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mux_5_to_1 #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [4:0] v, input logic [2:0] s);
    b1.ina = v[0];
    b1.inb = v[1];
    b1.inc = v[2];
    b1.ind = v[3];
    b1.ine = v[4];
    b1.sel = s;
  endtask

  initial begin
    reset = 1'b1;
    drive1(5'b11111, 3'd0);
    b8.ina = 8'hFF; b8.inb = 8'hFF; b8.inc = 8'hFF; b8.ind = 8'hFF; b8.ine = 8'hFF;
    b8.sel = 3'd0;

    // Reset held for two edges with all inputs high.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out1", {7'd0, b1.out}, 8'h00);
      check("rst_err1", {7'd0, b1.sel_err}, 8'h00);
      check("rst_out8", b8.out, 8'h00);
      check("rst_err8", {7'd0, b8.sel_err}, 8'h00);
    end

    // Reset wins over an out-of-range select.
    b1.sel = 3'd6;
    step();
    check("rst_prio_err", {7'd0, b1.sel_err}, 8'h00);

    // First edge after reset loads normally; one-hot walk.
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive1(5'(1 << k), 3'(k));
      step();
      check($sformatf("walk_out%0d", k), {7'd0, b1.out}, 8'h01);
      check($sformatf("walk_err%0d", k), {7'd0, b1.sel_err}, 8'h00);
      @(negedge clk);
    end

    // Isolation: selected input low while the others are high.
    drive1(5'b11110, 3'd0);
    step();
    check("iso_out", {7'd0, b1.out}, 8'h00);

    // Out-of-range selects, then back in range.
    for (int s = 5; s < 8; s++) begin
      @(negedge clk);
      drive1(5'b11111, 3'(s));
      step();
      check($sformatf("oor_out%0d", s), {7'd0, b1.out}, 8'h00);
      check($sformatf("oor_err%0d", s), {7'd0, b1.sel_err}, 8'h01);
    end
    @(negedge clk);
    drive1(5'b11111, 3'd2);
    step();
    check("inr_out", {7'd0, b1.out}, 8'h01);
    check("inr_err", {7'd0, b1.sel_err}, 8'h00);

    // Latency: a select change between edges does not reach out early.
    @(negedge clk);
    drive1(5'b00001, 3'd0);
    step();
    check("lat_pre", {7'd0, b1.out}, 8'h01);
    @(negedge clk);
    b1.sel = 3'd1;
    #2;
    check("lat_hold", {7'd0, b1.out}, 8'h01);
    step();
    check("lat_upd", {7'd0, b1.out}, 8'h00);

    // X on a non-selected input must not reach out.
    @(negedge clk);
    drive1(5'b00001, 3'd0);
    b1.inb = 1'bx;
    b1.ine = 1'bz;
    step();
    check("xprop", {7'd0, b1.out}, 8'h01);

    // Wide instance: alternate 0/4, reset for one edge mid-run, then resume.
    @(negedge clk);
    b8.ina = 8'hA5; b8.inb = 8'h11; b8.inc = 8'h22; b8.ind = 8'h33; b8.ine = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      b8.sel = (i % 2 == 0) ? 3'd0 : 3'd4;
      step();
      check($sformatf("wide_%0d", i), b8.out, (i % 2 == 0) ? 8'hA5 : 8'h3C);
      @(negedge clk);
    end
    reset = 1'b1;
    b8.sel = 3'd4;
    step();
    check("wide_rst", b8.out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    b8.sel = 3'd0;
    step();
    check("wide_res0", b8.out, 8'hA5);
    @(negedge clk);
    b8.sel = 3'd4;
    step();
    check("wide_res4", b8.out, 8'h3C);
    @(negedge clk);
    b8.sel = 3'd7;
    step();
    check("wide_oor", b8.out, 8'h00);
    check("wide_oor_err", {7'd0, b8.sel_err}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_5_to_1.md
MUX_5_TO_1 -- requirements
Module: mux_5_to_1

Interface
REQ-001 Parameter: WIDTH, default 1, data width of each input and of out.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: ina  input  WIDTH  data input 0, selected by sel=3'b000.
REQ-006 Port: inb  input  WIDTH  data input 1, selected by sel=3'b001.
REQ-007 Port: inc  input  WIDTH  data input 2, selected by sel=3'b010.
REQ-008 Port: ind  input  WIDTH  data input 3, selected by sel=3'b011.
REQ-009 Port: ine  input  WIDTH  data input 4, selected by sel=3'b100.
REQ-010 Port: sel  input  3  binary-encoded input select.
REQ-011 Port: out  output  WIDTH  registered selected data.
REQ-012 Port: sel_err  output  1  registered flag, high when the sampled sel was out of range (5..7).

Function
REQ-013 out and sel_err SHALL be driven directly from flip-flops; no combinational path from any input to any output.
REQ-014 On each rising clk edge with reset low, out SHALL load the input selected by sel as sampled at that edge.
REQ-015 Latency SHALL be exactly one clock: inputs/sel present at edge N appear on out after edge N; the value holds until the next edge.
REQ-016 Mapping SHALL be sel 0->ina, 1->inb, 2->inc, 3->ind, 4->ine.
REQ-017 For sel 5, 6 or 7, out SHALL load all-zeros and sel_err SHALL load 1.
REQ-018 For sel 0..4, sel_err SHALL load 0.
REQ-019 Non-selected inputs SHALL have no effect on out, including when all other inputs toggle on the same edge.
REQ-020 All WIDTH bits SHALL be selected by the same sel; no per-bit selection.
REQ-021 No enable, no handshake: the register updates every clock cycle.
REQ-022 X/Z on a non-selected input SHALL NOT propagate to out.

Reset
REQ-023 When reset is high at a rising clk edge, out SHALL become all-zeros and sel_err SHALL become 0, regardless of sel and data inputs.
REQ-024 Reset SHALL take priority over the select update on the same edge.
REQ-025 On the first edge with reset low after reset, the register SHALL load the selected input normally; no extra warm-up cycles.
REQ-026 Reset asserted mid-operation SHALL clear outputs on the next edge and hold them at zero while reset stays high.

Verification
REQ-027 Reset: reset=1 for 2 edges with ina..ine=1, sel=0 -> out=0 and sel_err=0 after each edge.
REQ-028 One-hot walk (WIDTH=1): for k=0..4, drive only input k high and sel=k -> out=1 one edge later, sel_err=0.
REQ-029 Isolation: ina=0, inb=inc=ind=ine=1, sel=0 -> out=0 one edge later.
REQ-030 Out of range: all inputs 1, sel=5, 6, 7 in turn -> out=0 and sel_err=1 after each edge; sel=2 next -> out=1, sel_err=0.
REQ-031 Latency: change sel between edges -> out stays unchanged until the next rising edge, then updates.
REQ-032 Wide/reset mid-run (WIDTH=8): ina=8'hA5, ine=8'h3C, alternate sel 0/4 every edge -> out alternates A5/3C; assert reset for one edge -> out=8'h00 after that edge, then resumes.
